mastermind_ctrl: RTL and testbench
==================================

Name: mastermind_ctrl

Overview:
Game sequencer for the Mastermind peg datapath.
- Latches the secret code and builds the player's guess from debounced button pulses.
- Presents the secret and guess to the combinational feedback evaluator, then captures its four 2-bit peg results.
- Counts turns and declares win or loss.
- Sits between the button debouncers / code generator and the feedback evaluator and SSD driver.

Parameters:
MAX_TURNS, 10, guesses allowed per game; legal range 1..15.
NUM_COLORS, 6, colours per digit; legal range 2..8; digit values 0..NUM_COLORS-1.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins a new game
secret  in  12  code to latch; [2:0]=digit0, [5:3]=digit1, [8:6]=digit2, [11:9]=digit3
btn_inc  in  1  single-cycle pulse; increment the digit under the cursor
btn_next  in  1  single-cycle pulse; advance the cursor
btn_submit  in  1  single-cycle pulse; submit the current guess
fb0..fb3  in  2 each  peg results from the evaluator (2=exact, 1=colour only, 0=none)
code0..code3  out  3 each  latched secret digits, to the evaluator
history0..history3  out  3 each  current guess digits, to the evaluator and display
cursor  out  2  index of the digit being edited
turn  out  4  number of guesses submitted this game
result0..result3  out  2 each  latched feedback of the last submitted guess
busy  out  1  high in EVAL
win  out  1  high in WIN
lose  out  1  high in LOSE

Behaviour:
- States: IDLE, EDIT, EVAL, WIN, LOSE. All outputs are registered.
- Reset (asynchronous, any state): state=IDLE; every output 0, including code*, history*, cursor, turn, result*, busy, win and lose.
- IDLE, WIN, LOSE:
  - start → latch secret into code0..3; any digit ≥ NUM_COLORS is stored as 0.
  - Same start also clears history*, cursor, turn, result*, win and lose; next state EDIT.
  - All buttons are ignored in these states.
  - WIN and LOSE hold all outputs until start or rst.
- EDIT:
  - btn_inc: history[cursor] += 1; NUM_COLORS-1 wraps to 0.
  - btn_next: cursor = (cursor+1) mod 4.
  - btn_inc and btn_next together: the increment applies to the old cursor digit, and the cursor also advances.
  - btn_submit has priority: when it is high, btn_inc and btn_next in the same cycle are ignored.
  - On btn_submit: turn += 1; next state EVAL.
  - start is ignored in EDIT and EVAL; there is no mid-game restart except via rst.
- EVAL (exactly one cycle, busy=1):
  - Sample fb0..3 into result0..3.
  - If fb0..3 are all 2 → WIN.
  - Else if turn == MAX_TURNS → LOSE.
  - Else → EDIT with cursor=0; history* is retained for editing.
  - Buttons are ignored in EVAL.
- Latency: submit sampled at edge N → busy visible after N; result*, win and lose visible after edge N+1.
- The evaluator is combinational, and history*/code* are stable from the submit edge onward, so fb is settled when sampled in EVAL.
- turn never exceeds MAX_TURNS; it saturates there through LOSE/WIN.
- A win on the final turn reports WIN, not LOSE: the win check has priority.
- Reset asserted during EVAL aborts the capture; outputs clear immediately, with no wait for a clock edge.

Test Plan:
1. Reset: assert rst mid-cycle with no clock → all outputs 0 at once; release, idle 5 cycles, pulse buttons → still IDLE, all outputs 0.
2. Win on turn 1:
   - Stimulus: start with secret=0x8D1 (digits 1,2,3,4); enter 1,2,3,4 via inc/next; submit.
   - Required: busy=1 for one cycle; then result0..3=2, win=1, turn=1.
   - Further buttons change nothing.
3. Wrap (NUM_COLORS=6): 7 btn_inc on digit0 → history0=1; 5 btn_next → cursor=1.
4. Loss (MAX_TURNS=10): secret 0x8D1; submit guess 0,0,0,0 ten times.
   - After each submit: result*=0 and cursor returns to 0.
   - After the 10th submit: lose=1, turn=10; an 11th submit is ignored and turn stays 10.
5. Simultaneous events:
   - btn_submit with btn_inc in EDIT → guess unchanged, EVAL entered.
   - btn_inc with btn_next at cursor=3 → history3 incremented, cursor=0.
6. Restart and clamp: start in WIN with secret=0xFFF → code0..3=0 (7 ≥ NUM_COLORS clamped); turn=0, result*=0, win=0, state EDIT.

Source files
------------

// File: rtl/mastermind_ctrl.sv
// rtl/mastermind_ctrl.sv - Mastermind game sequencer: code latch, guess editing, turn count, win/lose
module mastermind_ctrl #(
    parameter int MAX_TURNS  = 10,
    parameter int NUM_COLORS = 6
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [11:0] i_secret,
    input  logic        i_btn_inc,
    input  logic        i_btn_next,
    input  logic        i_btn_submit,
    input  logic [1:0]  i_fb0,
    input  logic [1:0]  i_fb1,
    input  logic [1:0]  i_fb2,
    input  logic [1:0]  i_fb3,
    output logic [2:0]  o_code0,
    output logic [2:0]  o_code1,
    output logic [2:0]  o_code2,
    output logic [2:0]  o_code3,
    output logic [2:0]  o_history0,
    output logic [2:0]  o_history1,
    output logic [2:0]  o_history2,
    output logic [2:0]  o_history3,
    output logic [1:0]  o_cursor,
    output logic [3:0]  o_turn,
    output logic [1:0]  o_result0,
    output logic [1:0]  o_result1,
    output logic [1:0]  o_result2,
    output logic [1:0]  o_result3,
    output logic        o_busy,
    output logic        o_win,
    output logic        o_lose
);

    typedef enum logic [2:0] {S_IDLE, S_EDIT, S_EVAL, S_WIN, S_LOSE} state_t;

    localparam logic [3:0] LP_NC    = 4'(NUM_COLORS);
    localparam logic [2:0] LP_TOP   = 3'(NUM_COLORS - 1);
    localparam logic [3:0] LP_TURNS = 4'(MAX_TURNS);

    state_t     r_state, w_next;
    logic [2:0] r_code [4];
    logic [2:0] r_hist [4];
    logic [1:0] r_res  [4];
    logic [1:0] r_cursor;
    logic [3:0] r_turn;
    logic       r_busy, r_win, r_lose;
    logic [1:0] w_fb [4];
    logic       w_all_exact;

    assign w_fb[0]     = i_fb0;
    assign w_fb[1]     = i_fb1;
    assign w_fb[2]     = i_fb2;
    assign w_fb[3]     = i_fb3;
    assign w_all_exact = (i_fb0 == 2'd2) && (i_fb1 == 2'd2) && (i_fb2 == 2'd2) && (i_fb3 == 2'd2);

    function automatic logic [2:0] f_clamp(input logic [2:0] d);
        return ({1'b0, d} < LP_NC) ? d : 3'd0;
    endfunction

    function automatic logic [2:0] f_inc(input logic [2:0] d);
        return (d == LP_TOP) ? 3'd0 : d + 3'd1;
    endfunction

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_WIN, S_LOSE: if (i_start) w_next = S_EDIT;
            S_EDIT:                if (i_btn_submit) w_next = S_EVAL;
            // Win check first so a correct final guess is reported as a win.
            S_EVAL:                w_next = w_all_exact ? S_WIN :
                                            (r_turn == LP_TURNS) ? S_LOSE : S_EDIT;
            default:               w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 4; i++) begin
                r_code[i] <= 3'd0;
                r_hist[i] <= 3'd0;
                r_res[i]  <= 2'd0;
            end
            r_cursor <= 2'd0;
            r_turn   <= 4'd0;
            r_busy   <= 1'b0;
            r_win    <= 1'b0;
            r_lose   <= 1'b0;
        end else begin
            r_busy <= (w_next == S_EVAL);
            r_win  <= (w_next == S_WIN);
            r_lose <= (w_next == S_LOSE);
            case (r_state)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (i_start) begin
                        for (int i = 0; i < 4; i++) begin
                            r_code[i] <= f_clamp(i_secret[3*i +: 3]);
                            r_hist[i] <= 3'd0;
                            r_res[i]  <= 2'd0;
                        end
                        r_cursor <= 2'd0;
                        r_turn   <= 4'd0;
                    end
                end
                S_EDIT: begin
                    if (i_btn_submit) begin
                        if (r_turn != LP_TURNS) r_turn <= r_turn + 4'd1;
                    end else begin
                        if (i_btn_inc)  r_hist[r_cursor] <= f_inc(r_hist[r_cursor]);
                        if (i_btn_next) r_cursor <= r_cursor + 2'd1;
                    end
                end
                S_EVAL: begin
                    for (int i = 0; i < 4; i++) r_res[i] <= w_fb[i];
                    r_cursor <= 2'd0;
                end
                default: ;
            endcase
        end
    end

    assign o_code0    = r_code[0];
    assign o_code1    = r_code[1];
    assign o_code2    = r_code[2];
    assign o_code3    = r_code[3];
    assign o_history0 = r_hist[0];
    assign o_history1 = r_hist[1];
    assign o_history2 = r_hist[2];
    assign o_history3 = r_hist[3];
    assign o_cursor   = r_cursor;
    assign o_turn     = r_turn;
    assign o_result0  = r_res[0];
    assign o_result1  = r_res[1];
    assign o_result2  = r_res[2];
    assign o_result3  = r_res[3];
    assign o_busy     = r_busy;
    assign o_win      = r_win;
    assign o_lose     = r_lose;

endmodule

// File: tb/tb_mastermind_ctrl.sv
// tb/tb_mastermind_ctrl.sv - table-driven bench for mastermind_ctrl
module tb_mastermind_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, btn_inc = 1'b0, btn_next = 1'b0, btn_submit = 1'b0;
    logic [11:0] secret = 12'd0;
    logic [7:0]  fb = 8'd0;
    logic [2:0]  code0, code1, code2, code3, hist0, hist1, hist2, hist3;
    logic [1:0]  cursor, res0, res1, res2, res3;
    logic [3:0]  turn;
    logic        busy, win, lose;

    int n_checks = 0;
    int n_errors = 0;

    mastermind_ctrl #(.MAX_TURNS(10), .NUM_COLORS(6)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_secret(secret),
        .i_btn_inc(btn_inc), .i_btn_next(btn_next), .i_btn_submit(btn_submit),
        .i_fb0(fb[1:0]), .i_fb1(fb[3:2]), .i_fb2(fb[5:4]), .i_fb3(fb[7:6]),
        .o_code0(code0), .o_code1(code1), .o_code2(code2), .o_code3(code3),
        .o_history0(hist0), .o_history1(hist1), .o_history2(hist2), .o_history3(hist3),
        .o_cursor(cursor), .o_turn(turn),
        .o_result0(res0), .o_result1(res1), .o_result2(res2), .o_result3(res3),
        .o_busy(busy), .o_win(win), .o_lose(lose)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [11:0] sec;
        logic        inc, nxt, sub;
        logic [7:0]  fb;
        logic [11:0] e_code, e_hist;
        logic [1:0]  e_cur;
        logic [3:0]  e_turn;
        logic [7:0]  e_res;
        logic        e_busy, e_win, e_lose;
    } vec_t;

    vec_t vq[$];

    function automatic logic [40:0] pk(input logic [11:0] c, input logic [11:0] h, input logic [1:0] cu,
                                       input logic [3:0] t, input logic [7:0] r, input logic b,
                                       input logic w, input logic l);
        return {c, h, cu, t, r, b, w, l};
    endfunction

    function automatic logic [40:0] outs();
        return pk({code3, code2, code1, code0}, {hist3, hist2, hist1, hist0}, cursor, turn,
                  {res3, res2, res1, res0}, busy, win, lose);
    endfunction

    task automatic check(input string name, input logic [40:0] exp);
        logic [40:0] act;
        act = outs();
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic [11:0] sec, input logic inc, input logic nxt,
                       input logic sub, input logic [7:0] f, input logic [11:0] ec, input logic [11:0] eh,
                       input logic [1:0] ecu, input logic [3:0] et, input logic [7:0] er,
                       input logic eb, input logic ew, input logic el);
        vec_t v;
        v.st = st; v.sec = sec; v.inc = inc; v.nxt = nxt; v.sub = sub; v.fb = f;
        v.e_code = ec; v.e_hist = eh; v.e_cur = ecu; v.e_turn = et; v.e_res = er;
        v.e_busy = eb; v.e_win = ew; v.e_lose = el;
        vq.push_back(v);
    endtask

    task automatic cyc(input logic st, input logic [11:0] sec, input logic inc, input logic nxt,
                       input logic sub, input logic [7:0] f);
        start = st; secret = sec; btn_inc = inc; btn_next = nxt; btn_submit = sub; fb = f;
        @(posedge clk);
        #1;
        start = 1'b0; btn_inc = 1'b0; btn_next = 1'b0; btn_submit = 1'b0;
    endtask

    initial begin
        // Win on turn 1, then simultaneous-button corners
        add(1, 12'h8D1, 0,0,0, 8'h00, 12'h8D1, 12'h000, 0, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 1,0,0, 8'h00, 12'h8D1, 12'h001, 0, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 0,1,0, 8'h00, 12'h8D1, 12'h001, 1, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 1,0,0, 8'h00, 12'h8D1, 12'h009, 1, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 1,0,0, 8'h00, 12'h8D1, 12'h011, 1, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 0,1,0, 8'h00, 12'h8D1, 12'h011, 2, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 1,0,0, 8'h00, 12'h8D1, 12'h051, 2, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 1,0,0, 8'h00, 12'h8D1, 12'h091, 2, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 1,0,0, 8'h00, 12'h8D1, 12'h0D1, 2, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 0,1,0, 8'h00, 12'h8D1, 12'h0D1, 3, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 1,0,0, 8'h00, 12'h8D1, 12'h2D1, 3, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 1,0,0, 8'h00, 12'h8D1, 12'h4D1, 3, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 1,0,0, 8'h00, 12'h8D1, 12'h6D1, 3, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 1,1,0, 8'h00, 12'h8D1, 12'h8D1, 0, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 1,0,1, 8'h00, 12'h8D1, 12'h8D1, 0, 1, 8'h00, 1,0,0);
        add(0, 12'h000, 0,0,0, 8'hAA, 12'h8D1, 12'h8D1, 0, 1, 8'hAA, 0,1,0);
        add(0, 12'h000, 1,0,0, 8'h00, 12'h8D1, 12'h8D1, 0, 1, 8'hAA, 0,1,0);
        add(0, 12'h000, 0,1,0, 8'h00, 12'h8D1, 12'h8D1, 0, 1, 8'hAA, 0,1,0);
        add(0, 12'h000, 0,0,1, 8'h00, 12'h8D1, 12'h8D1, 0, 1, 8'hAA, 0,1,0);
        // Restart from WIN with out-of-range digits
        add(1, 12'hFFF, 0,0,0, 8'h00, 12'h000, 12'h000, 0, 0, 8'h00, 0,0,0);
        // Colour wrap: seven increments on digit0
        add(0, 12'h000, 1,0,0, 8'h00, 12'h000, 12'h001, 0, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 1,0,0, 8'h00, 12'h000, 12'h002, 0, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 1,0,0, 8'h00, 12'h000, 12'h003, 0, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 1,0,0, 8'h00, 12'h000, 12'h004, 0, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 1,0,0, 8'h00, 12'h000, 12'h005, 0, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 1,0,0, 8'h00, 12'h000, 12'h000, 0, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 1,0,0, 8'h00, 12'h000, 12'h001, 0, 0, 8'h00, 0,0,0);
        // Cursor wrap: five advances
        add(0, 12'h000, 0,1,0, 8'h00, 12'h000, 12'h001, 1, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 0,1,0, 8'h00, 12'h000, 12'h001, 2, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 0,1,0, 8'h00, 12'h000, 12'h001, 3, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 0,1,0, 8'h00, 12'h000, 12'h001, 0, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 0,1,0, 8'h00, 12'h000, 12'h001, 1, 0, 8'h00, 0,0,0);
        // start ignored mid-game; non-winning evaluation returns to EDIT at cursor 0
        add(1, 12'h8D1, 0,0,0, 8'h00, 12'h000, 12'h001, 1, 0, 8'h00, 0,0,0);
        add(0, 12'h000, 0,0,1, 8'h00, 12'h000, 12'h001, 1, 1, 8'h00, 1,0,0);
        add(0, 12'h000, 0,0,0, 8'hA8, 12'h000, 12'h001, 0, 1, 8'hA8, 0,0,0);

        // Reset state, asserted from time zero
        #2;
        check("reset_initial", 41'd0);
        #10 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vq.size(); i++) begin
            cyc(vq[i].st, vq[i].sec, vq[i].inc, vq[i].nxt, vq[i].sub, vq[i].fb);
            check($sformatf("vec%0d", i),
                  pk(vq[i].e_code, vq[i].e_hist, vq[i].e_cur, vq[i].e_turn, vq[i].e_res,
                     vq[i].e_busy, vq[i].e_win, vq[i].e_lose));
        end

        // Asynchronous reset while in EVAL clears everything without a clock edge
        cyc(0, 12'h000, 0, 0, 1, 8'hAA);
        check("eval_before_rst", pk(12'h000, 12'h001, 0, 2, 8'hA8, 1, 0, 0));
        #2 rst = 1'b1;
        #1;
        check("rst_async_eval", 41'd0);
        #3 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        cyc(0, 12'h000, 1, 0, 0, 8'h00);
        cyc(0, 12'h000, 0, 1, 0, 8'h00);
        cyc(0, 12'h000, 0, 0, 1, 8'hAA);
        check("idle_buttons_ignored", 41'd0);

        // Loss after ten wrong guesses, turn saturates
        cyc(1, 12'h8D1, 0, 0, 0, 8'h00);
        check("loss_start", pk(12'h8D1, 12'h000, 0, 0, 8'h00, 0, 0, 0));
        for (int t = 1; t <= 10; t++) begin
            cyc(0, 12'h000, 0, 1, 0, 8'h00);
            cyc(0, 12'h000, 0, 0, 1, 8'h00);
            check($sformatf("loss_submit%0d", t), pk(12'h8D1, 12'h000, 1, 4'(t), 8'h00, 1, 0, 0));
            cyc(0, 12'h000, 0, 0, 0, 8'h00);
            check($sformatf("loss_eval%0d", t), pk(12'h8D1, 12'h000, 0, 4'(t), 8'h00, 0, 0, t == 10));
        end
        cyc(0, 12'h000, 1, 1, 1, 8'hAA);
        cyc(0, 12'h000, 0, 0, 0, 8'hAA);
        check("loss_extra_submit", pk(12'h8D1, 12'h000, 0, 10, 8'h00, 0, 0, 1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
